fifo_ctrl16: RTL
================

// Module: fifo_ctrl16
// PURPOSE
// - Pointer/flag controller for the 16x8 sync-write/async-read FIFO memory.
// - Drives the memory's WADD, WE and RADD; reports FULL, EMPTY, occupancy and error pulses.
// - Read side is first-word-fall-through: memory DOUT holds the head word whenever EMPTY=0.
// - POP acknowledges that the head word is consumed; data is never presented one cycle late.
// PARAMETERS
// - AW        4    address width; depth = 2**AW (16)
// - AF_LEVEL  14   ALMOST_FULL asserted when COUNT >= AF_LEVEL
// - AE_LEVEL  2    ALMOST_EMPTY asserted when COUNT <= AE_LEVEL
// PORTS
// - CLK           in   1     clock; all state changes on posedge
// - RST           in   1     reset, asynchronous, active-high
// - PUSH          in   1     write request; data already on memory DIN this cycle
// - POP           in   1     read acknowledge; head word consumed this cycle
// - WE            out  1     memory write enable (combinational)
// - WADD          out  AW    memory write address (registered write pointer)
// - RADD          out  AW    memory read address (registered read pointer)
// - FULL          out  1     registered; COUNT == 2**AW
// - EMPTY         out  1     registered; COUNT == 0
// - ALMOST_FULL   out  1     registered; COUNT >= AF_LEVEL
// - ALMOST_EMPTY  out  1     registered; COUNT <= AE_LEVEL
// - COUNT         out  AW+1  registered occupancy, 0..2**AW
// - OVF           out  1     registered 1-cycle pulse: PUSH rejected the previous cycle
// - UDF           out  1     registered 1-cycle pulse: POP rejected the previous cycle
// BEHAVIOUR
// - Reset (async, RST=1):
//   - WADD=0, RADD=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1.
//   - FULL=0, ALMOST_FULL=0 (for AF_LEVEL>0), OVF=0, UDF=0.
//   - WE is forced 0 while RST=1.
// - Accept rules, evaluated on current registered state:
//   - push_ok = PUSH & (~FULL | POP).
//   - pop_ok  = POP & ~EMPTY.
//   - WE = push_ok & ~RST.
// - When FULL, PUSH with POP in the same cycle is accepted.
//   - The head word is read asynchronously before the edge, then overwritten at the edge.
// - When EMPTY, PUSH with POP in the same cycle: the push is accepted and the pop is rejected.
//   - UDF pulses on the next cycle.
// - On posedge:
//   - WADD += push_ok; RADD += pop_ok. Both wrap modulo 2**AW (15 -> 0).
//   - COUNT += push_ok - pop_ok. Simultaneous accept leaves COUNT unchanged.
// - All flags are recomputed from the next COUNT and registered, so they are valid in the cycle after the op.
// - Latency:
//   - A pushed word is visible on DOUT, with EMPTY=0, one cycle after the push edge.
//   - After a pop edge, DOUT shows the next word combinationally.
// - Rejection:
//   - OVF = PUSH & ~push_ok; UDF = POP & ~pop_ok.
//   - Each is registered for exactly one cycle; a rejected request has no other effect.
// - FULL and EMPTY are never both 1. COUNT never exceeds 2**AW and never underflows.
// - Reset asserted mid-operation discards contents immediately (asynchronous).
//   - Memory contents are not cleared; they are unreachable because EMPTY=1.
// STRUCTURE
// - Shared package fifo_pkg:
//   - FIFO_AW=4, FIFO_DEPTH=16, FIFO_DW=8.
//   - Default AF/AE levels.
//   - Typedefs ptr_t [AW-1:0] and cnt_t [AW:0].
// - One sub-module, fifo_ptr: AW-bit wrapping pointer with async RST and an INC enable.
//   - Instantiated twice, for WADD and RADD.
// - Count/flag logic and the accept logic live in fifo_ctrl16.
// - Top level pairs fifo_ctrl16 with the memory via WADD/WE/RADD.
// TESTING (bench instantiates fifo_ctrl16 + 16x8 memory, checks DOUT)
// - Reset then idle:
//   - Expect EMPTY=1, ALMOST_EMPTY=1, COUNT=0, WADD=RADD=0, WE=0.
//   - POP gives UDF=1 for one cycle, RADD stays 0.
// - Push 0x01..0x10 (16 words):
//   - Expect FULL=1, COUNT=16, WADD=0, ALMOST_FULL from COUNT=14.
//   - 17th PUSH gives WE=0, OVF pulse, COUNT stays 16.
// - From full, PUSH+POP of 0xAA:
//   - DOUT=0x01 before the edge; COUNT stays 16; FULL stays 1.
//   - After 15 POPs, DOUT=0xAA.
// - Empty with PUSH+POP of 0x55:
//   - WE=1, UDF pulse; next cycle EMPTY=0, COUNT=1, DOUT=0x55.
// - Wrap: 40 cycles of alternating push/pop with an incrementing pattern.
//   - Pointers wrap 15->0; DOUT order matches the push order; COUNT stays in 0..1.
// - Assert RST mid-burst at COUNT=9:
//   - Outputs reach reset values without a clock edge.
//   - First push after release writes WADD=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing, default levels and pointer/count types
// for the 16x8 FIFO controller.
package fifo_pkg;
  localparam int FIFO_AW = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW = 8;
  localparam int FIFO_AF_LEVEL = 14;
  localparam int FIFO_AE_LEVEL = 2;

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0] cnt_t;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW-bit pointer with async active-high reset
// and an increment enable.
module fifo_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end
endmodule

// File: rtl/fifo_ctrl16.sv
// Pointer/flag controller for a first-word-fall-through FIFO
// built on a sync-write/async-read memory.
import fifo_pkg::*;

module fifo_ctrl16 #(
  parameter int AW = FIFO_AW,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PUSH,
  input  logic          POP,
  output logic          WE,
  output logic [AW-1:0] WADD,
  output logic [AW-1:0] RADD,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ALMOST_FULL,
  output logic          ALMOST_EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic          UDF
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(1) << AW;
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_LEVEL);

  logic push_ok;
  logic pop_ok;
  logic [AW:0] next_count;

  // A full FIFO still takes a push when the head leaves the same cycle.
  assign push_ok = PUSH & (~FULL | POP);
  assign pop_ok = POP & ~EMPTY;
  assign WE = push_ok & ~RST;

  fifo_ptr #(.AW(AW)) u_wptr (
    .clk(CLK),
    .rst(RST),
    .inc(push_ok),
    .ptr(WADD)
  );

  fifo_ptr #(.AW(AW)) u_rptr (
    .clk(CLK),
    .rst(RST),
    .inc(pop_ok),
    .ptr(RADD)
  );

  always_comb begin
    next_count = COUNT;
    unique case (1'b1)
      push_ok & ~pop_ok: next_count = COUNT + (AW+1)'(1);
      pop_ok & ~push_ok: next_count = COUNT - (AW+1)'(1);
      default: next_count = COUNT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      ALMOST_FULL <= (AF_C == '0);
      ALMOST_EMPTY <= 1'b1;
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      COUNT <= next_count;
      FULL <= (next_count == DEPTH_C);
      EMPTY <= (next_count == '0);
      ALMOST_FULL <= (next_count >= AF_C);
      ALMOST_EMPTY <= (next_count <= AE_C);
      OVF <= PUSH & ~push_ok;
      UDF <= POP & ~pop_ok;
    end
  end
endmodule
